// File: rtl/decode_queue_ctrl_pkg.sv
// decode_queue_ctrl_pkg: RV32 opcodes, instruction field positions and queue entry type
package decode_queue_ctrl_pkg;
  localparam logic [6:0] OP_OP       = 7'b0110011;
  localparam logic [6:0] OP_IMM      = 7'b0010011;
  localparam logic [6:0] OP_LOAD     = 7'b0000011;
  localparam logic [6:0] OP_STORE    = 7'b0100011;
  localparam logic [6:0] OP_BRANCH   = 7'b1100011;
  localparam logic [6:0] OP_JAL      = 7'b1101111;
  localparam logic [6:0] OP_JALR     = 7'b1100111;
  localparam logic [6:0] OP_LUI      = 7'b0110111;
  localparam logic [6:0] OP_AUIPC    = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
  localparam int OPCODE_LSB = 0;
  localparam int RD_LSB     = 7;
  localparam int FUNCT3_LSB = 12;
  localparam int RS1_LSB    = 15;
  localparam int RS2_LSB    = 20;
  localparam int FUNCT7_LSB = 25;
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;
  function automatic logic opcode_legal(input logic [6:0] op);
    return op inside {OP_OP, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL,
                      OP_JALR, OP_LUI, OP_AUIPC, OP_SYSTEM, OP_MISC_MEM};
  endfunction
endpackage

// File: rtl/decode_queue_ctrl_decode.sv
// decode_queue_ctrl_decode: combinational field slicing of the head entry; opcode check under DECODE_ILLEGAL_CHECK_EN
module decode_queue_ctrl_decode
  import decode_queue_ctrl_pkg::*;
(
  input  entry_t      head,
  output logic [6:0]  opcode,
  output logic [4:0]  rd,
  output logic [2:0]  funct3,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [6:0]  funct7,
  output logic [31:0] pc,
  output logic        illegal_op
);
  assign opcode = head.instr[OPCODE_LSB +: 7];
  assign rd     = head.instr[RD_LSB +: 5];
  assign funct3 = head.instr[FUNCT3_LSB +: 3];
  assign rs1    = head.instr[RS1_LSB +: 5];
  assign rs2    = head.instr[RS2_LSB +: 5];
  assign funct7 = head.instr[FUNCT7_LSB +: 7];
  assign pc     = head.pc;
`ifdef DECODE_ILLEGAL_CHECK_EN
  assign illegal_op = !opcode_legal(opcode);
`else
  assign illegal_op = 1'b0;
`endif
endmodule

// File: rtl/decode_queue_ctrl.sv
// decode_queue_ctrl: circular fetch-to-decode instruction queue with flush; DECODE_ILLEGAL_CHECK_EN enables illegal-opcode flagging
module decode_queue_ctrl
  import decode_queue_ctrl_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             fetch_valid,
  input  logic [31:0]      fetch_instr,
  input  logic [31:0]      fetch_pc,
  output logic             fetch_ready,
  output logic             dec_valid,
  input  logic             dec_ready,
  output logic [6:0]       dec_opcode,
  output logic [4:0]       dec_rd,
  output logic [2:0]       dec_funct3,
  output logic [4:0]       dec_rs1,
  output logic [4:0]       dec_rs2,
  output logic [6:0]       dec_funct7,
  output logic [31:0]      dec_pc,
  output logic             dec_illegal,
  output logic [CNT_W-1:0] occupancy
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  entry_t mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic push, pop, head_illegal;
  assign fetch_ready = occupancy != CNT_W'(DEPTH);
  assign dec_valid   = occupancy != '0;
  assign push        = fetch_valid && fetch_ready && !flush;
  assign pop         = dec_valid && dec_ready && !flush;
  assign dec_illegal = dec_valid && head_illegal;
  // pointer and occupancy bookkeeping; flush discards everything and wins over push/pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr == LAST ? '0 : wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr == LAST ? '0 : rd_ptr + PW'(1);
      occupancy <= occupancy + CNT_W'(push) - CNT_W'(pop);
    end
  end
  // entry storage is never cleared; validity comes only from occupancy
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{instr: fetch_instr, pc: fetch_pc};
  end
  decode_queue_ctrl_decode u_decode (
    .head       (mem[rd_ptr]),
    .opcode     (dec_opcode),
    .rd         (dec_rd),
    .funct3     (dec_funct3),
    .rs1        (dec_rs1),
    .rs2        (dec_rs2),
    .funct7     (dec_funct7),
    .pc         (dec_pc),
    .illegal_op (head_illegal)
  );
endmodule

// File: doc/decode_queue_ctrl.md
DECODE_QUEUE_CTRL -- requirements
Module: decode_queue_ctrl

Interface
REQ-001 Parameter DEPTH, default 4, queue entries; power of two, 2..16.
REQ-002 Parameter CNT_W, default $clog2(DEPTH)+1, occupancy counter width.
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 flush  input  1  discard all queued instructions (mispredict/exception).
REQ-006 fetch_valid  input  1  fetch offers an instruction.
REQ-007 fetch_instr  input  32  raw RV32 instruction word.
REQ-008 fetch_pc  input  32  PC of fetch_instr.
REQ-009 fetch_ready  output  1  queue accepts; equals !full.
REQ-010 dec_valid  output  1  head entry valid; equals !empty.
REQ-011 dec_ready  input  1  rename stage consumes head.
REQ-012 dec_opcode 7, dec_rd 5, dec_funct3 3, dec_rs1 5, dec_rs2 5, dec_funct7 7  outputs  head fields at bits [6:0],[11:7],[14:12],[19:15],[24:20],[31:25].
REQ-013 dec_pc  output  32  PC of head entry.
REQ-014 dec_illegal  output  1  head opcode unsupported (see Configuration).
REQ-015 occupancy  output  CNT_W  entries held.

Function
REQ-016 Push SHALL occur when fetch_valid && fetch_ready && !flush at a rising edge; pop when dec_valid && dec_ready && !flush.
REQ-017 Queue SHALL be a circular buffer with wr_ptr/rd_ptr wrapping DEPTH-1 -> 0.
REQ-018 Field outputs SHALL be combinational slices of the head entry; latency fetch-accept to dec_valid is exactly 1 cycle.
REQ-019 Simultaneous push and pop SHALL leave occupancy unchanged, including when empty->push is impossible (pop requires dec_valid) and full (push blocked since fetch_ready=0).
REQ-020 fetch_ready SHALL be 0 iff occupancy==DEPTH; no combinational path dec_ready -> fetch_ready.
REQ-021 flush SHALL take priority: next cycle occupancy=0, pointers=0, dec_valid=0; same-cycle push and pop ignored.
REQ-022 Field outputs while dec_valid=0 are don't-care; verification SHALL not check them.
REQ-023 Entries SHALL be popped in strict FIFO order; no entry lost or duplicated.

Reset
REQ-024 On rst_n=0: pointers=0, occupancy=0, dec_valid=0, fetch_ready=1, dec_illegal=0; storage not cleared.
REQ-025 Reset mid-stream SHALL discard all entries; first push after release appears at head next cycle.

Configuration
REQ-026 Macro DECODE_ILLEGAL_CHECK_EN defined: dec_illegal=dec_valid && opcode not in {0110011,0010011,0000011,0100011,1100011,1101111,1100111,0110111,0010111,1110011,0001111}.
REQ-027 Macro undefined: dec_illegal tied 0; port still present; no other behaviour change.

Structure
REQ-028 Shared package SHALL hold RV32 opcode localparams, field bit-position constants and a packed queue-entry typedef (instr, pc).
REQ-029 One sub-module decode (field-slicing, combinational) SHALL be instantiated on the head entry.

Verification
REQ-030 Reset, push 0x00B50533 pc 0x100 -> next cycle dec_valid=1, opcode 0x33, rd 10, rs1 10, rs2 11, funct3 0, funct7 0, pc 0x100.
REQ-031 dec_ready=0, push 4 entries -> occupancy 4, fetch_ready=0; 5th offer not accepted; drain yields entries 1..4 in order.
REQ-032 Full queue, dec_ready=1 and fetch_valid=1 same cycle -> pop only; next cycle occupancy 3, fetch_ready=1.
REQ-033 Occupancy 3, flush with fetch_valid=1, dec_ready=1 -> next cycle occupancy 0, dec_valid=0, no entry emitted.
REQ-034 10 push/pop cycles at occupancy 1 -> pointers wrap; output order equals input order.
REQ-035 With DECODE_ILLEGAL_CHECK_EN, push 0x0000007F -> dec_illegal=1; without macro -> dec_illegal=0.
